// File: rtl/kronos_csr_arb.sv
// kronos_csr_arb: round-robin arbiter sequencing core/debug read-modify-write access to one CSR file
// Ports: clk/rst (sync, active-high); core_* and dbg_* requesters (vld/addr/op/wdata/wen in,
// rdy/rdata/err out); csr_* port to the register block (addr, rd_req, rd_vld, rd_data, wr_en, wr_data).
module kronos_csr_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_vld_i,
    output logic        core_rdy_o,
    input  logic [11:0] core_addr_i,
    input  logic [1:0]  core_op_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_wen_i,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    input  logic        dbg_vld_i,
    output logic        dbg_rdy_o,
    input  logic [11:0] dbg_addr_i,
    input  logic [1:0]  dbg_op_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dbg_wen_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,
    output logic [11:0] csr_addr_o,
    output logic        csr_rd_req_o,
    input  logic        csr_rd_vld_i,
    input  logic [31:0] csr_rd_data_i,
    output logic        csr_wr_en_o,
    output logic [31:0] csr_wr_data_o
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t        state_q;
    logic          last_dbg_q, gnt_dbg_q, wen_q, err_q, rd_req_q, wr_en_q, core_rdy_q, dbg_rdy_q;
    logic [1:0]    op_q;
    logic [11:0]   addr_q;
    logic [31:0]   wdata_q, rdata_q, wr_data_q;
    logic [CW-1:0] cnt_q;
    logic          gnt_dbg_d, do_wr_d, timeout_d;
    logic [31:0]   wr_data_d;
    // on a tie the side that did not win last time gets the grant
    always_comb begin
        gnt_dbg_d = dbg_vld_i & (~core_vld_i | ~last_dbg_q);
        do_wr_d   = wen_q & (op_q != 2'b00);
        timeout_d = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
        wr_data_d = op_q == 2'b01 ? wdata_q :
                    op_q == 2'b10 ? (csr_rd_data_i | wdata_q) : (csr_rd_data_i & ~wdata_q);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_dbg_q <= 1'b1;
            gnt_dbg_q  <= 1'b0;
            op_q       <= 2'b00;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            rd_req_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            core_rdy_q <= 1'b0;
            dbg_rdy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_vld_i | dbg_vld_i) begin
                        gnt_dbg_q  <= gnt_dbg_d;
                        last_dbg_q <= gnt_dbg_d;
                        addr_q     <= gnt_dbg_d ? dbg_addr_i : core_addr_i;
                        op_q       <= gnt_dbg_d ? dbg_op_i : core_op_i;
                        wdata_q    <= gnt_dbg_d ? dbg_wdata_i : core_wdata_i;
                        wen_q      <= gnt_dbg_d ? dbg_wen_i : core_wen_i;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        rd_req_q   <= 1'b1;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    // read data arriving on the timeout cycle still counts as a good read
                    if (csr_rd_vld_i) begin
                        rdata_q  <= csr_rd_data_i;
                        rd_req_q <= 1'b0;
                        if (do_wr_d) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= wr_data_d;
                            state_q   <= WRITE;
                        end else begin
                            core_rdy_q <= ~gnt_dbg_q;
                            dbg_rdy_q  <= gnt_dbg_q;
                            state_q    <= RESP;
                        end
                    end else if (timeout_d) begin
                        err_q      <= 1'b1;
                        rd_req_q   <= 1'b0;
                        core_rdy_q <= ~gnt_dbg_q;
                        dbg_rdy_q  <= gnt_dbg_q;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    wr_en_q    <= 1'b0;
                    core_rdy_q <= ~gnt_dbg_q;
                    dbg_rdy_q  <= gnt_dbg_q;
                    state_q    <= RESP;
                end
                default: begin
                    core_rdy_q <= 1'b0;
                    dbg_rdy_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end
    assign core_rdy_o    = core_rdy_q;
    assign dbg_rdy_o     = dbg_rdy_q;
    assign core_rdata_o  = rdata_q;
    assign dbg_rdata_o   = rdata_q;
    assign core_err_o    = err_q;
    assign dbg_err_o     = err_q;
    assign csr_addr_o    = addr_q;
    assign csr_rd_req_o  = rd_req_q;
    assign csr_wr_en_o   = wr_en_q;
    assign csr_wr_data_o = wr_data_q;
endmodule

// File: tb/tb_kronos_csr_arb.sv
// tb_kronos_csr_arb: directed and randomized checks of kronos_csr_arb against a transaction-level model
module tb_kronos_csr_arb;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0;
    logic        rst;
    logic        core_vld, core_rdy, core_wen, core_err;
    logic [11:0] core_addr;
    logic [1:0]  core_op;
    logic [31:0] core_wdata, core_rdata;
    logic        dbg_vld, dbg_rdy, dbg_wen, dbg_err;
    logic [11:0] dbg_addr;
    logic [1:0]  dbg_op;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic [11:0] csr_addr;
    logic        csr_rd_req, csr_rd_vld, csr_wr_en;
    logic [31:0] csr_rd_data, csr_wr_data;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          last_dbg_m;
    logic [31:0] rdata_m;

    kronos_csr_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .core_vld_i(core_vld), .core_rdy_o(core_rdy), .core_addr_i(core_addr), .core_op_i(core_op),
        .core_wdata_i(core_wdata), .core_wen_i(core_wen), .core_rdata_o(core_rdata), .core_err_o(core_err),
        .dbg_vld_i(dbg_vld), .dbg_rdy_o(dbg_rdy), .dbg_addr_i(dbg_addr), .dbg_op_i(dbg_op),
        .dbg_wdata_i(dbg_wdata), .dbg_wen_i(dbg_wen), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
        .csr_addr_o(csr_addr), .csr_rd_req_o(csr_rd_req), .csr_rd_vld_i(csr_rd_vld),
        .csr_rd_data_i(csr_rd_data), .csr_wr_en_o(csr_wr_en), .csr_wr_data_o(csr_wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request round: model predicts winner, write, error, data and latency; dly is the
    // READ-cycle index (0-based) on which the CSR side answers.
    task automatic txn(input bit cv, input bit dv, input logic [1:0] op_c, input logic [1:0] op_d,
                       input logic [31:0] wd_c, input logic [31:0] wd_d, input bit wen_c, input bit wen_d,
                       input logic [11:0] ad_c, input logic [11:0] ad_d, input int dly, input logic [31:0] rd);
        bit          wdbg, wen, exp_wr, exp_err, got_rdy, addr_seen;
        logic [1:0]  op;
        logic [31:0] wd, exp_wd, wr_dat;
        logic [11:0] ad;
        int          exp_lat, rcnt, wr_n, wr_cyc;
        wdbg       = dv && (!cv || !last_dbg_m);
        last_dbg_m = wdbg;
        op  = wdbg ? op_d : op_c;
        wd  = wdbg ? wd_d : wd_c;
        wen = wdbg ? wen_d : wen_c;
        ad  = wdbg ? ad_d : ad_c;
        exp_err = dly >= TIMEOUT;
        exp_wr  = !exp_err && wen && op != 2'b00;
        exp_wd  = op == 2'b01 ? wd : op == 2'b10 ? (rd | wd) : (rd & ~wd);
        if (!exp_err) rdata_m = rd;
        exp_lat = exp_err ? TIMEOUT + 1 : dly + 2 + int'(exp_wr);
        @(negedge clk);
        core_vld = cv; core_op = op_c; core_wdata = wd_c; core_wen = wen_c; core_addr = ad_c;
        dbg_vld = dv; dbg_op = op_d; dbg_wdata = wd_d; dbg_wen = wen_d; dbg_addr = ad_d;
        csr_rd_data = rd; csr_rd_vld = 1'b0;
        rcnt = 0; wr_n = 0; wr_cyc = 0; wr_dat = '0; got_rdy = 0; addr_seen = 0;
        for (int i = 1; i <= 40 && !got_rdy; i++) begin
            @(negedge clk);
            if (csr_wr_en) begin wr_n++; wr_cyc = i; wr_dat = csr_wr_data; end
            if (csr_rd_req && !addr_seen) begin addr_seen = 1; chk("csr_addr", 32'(csr_addr), 32'(ad)); end
            if (core_rdy || dbg_rdy) begin
                got_rdy = 1;
                chk("rdy_latency", 32'(i), 32'(exp_lat));
                chk("rdy_winner", 32'(dbg_rdy), 32'(wdbg));
                chk("rdy_other", 32'(wdbg ? core_rdy : dbg_rdy), 32'd0);
                chk("rdata", wdbg ? dbg_rdata : core_rdata, rdata_m);
                chk("err", 32'(wdbg ? dbg_err : core_err), 32'(exp_err));
                core_vld = 1'b0; dbg_vld = 1'b0;
            end
            csr_rd_vld = csr_rd_req && !got_rdy && rcnt == dly;
            if (csr_rd_req) rcnt++;
        end
        csr_rd_vld = 1'b0;
        chk("rdy_seen", 32'(got_rdy), 32'd1);
        chk("rd_req_seen", 32'(addr_seen), 32'd1);
        chk("wr_count", 32'(wr_n), 32'(exp_wr));
        if (exp_wr) begin
            chk("wr_cycle", 32'(wr_cyc), 32'(exp_lat - 1));
            chk("wr_data", wr_dat, exp_wd);
        end
    endtask

    initial begin
        int r, dly;
        bit cv, dv;
        rst = 1'b1;
        core_vld = 0; core_op = 0; core_wdata = 0; core_wen = 0; core_addr = 0;
        dbg_vld = 0; dbg_op = 0; dbg_wdata = 0; dbg_wen = 0; dbg_addr = 0;
        csr_rd_vld = 0; csr_rd_data = 0;
        last_dbg_m = 1'b1; rdata_m = '0;
        repeat (3) @(negedge clk);
        chk("rst_core_rdy", 32'(core_rdy), 0);
        chk("rst_dbg_rdy", 32'(dbg_rdy), 0);
        chk("rst_err", 32'(core_err | dbg_err), 0);
        chk("rst_rd_req", 32'(csr_rd_req), 0);
        chk("rst_wr_en", 32'(csr_wr_en), 0);
        chk("rst_addr", 32'(csr_addr), 0);
        chk("rst_wr_data", csr_wr_data, 0);
        chk("rst_rdata", core_rdata, 0);
        rst = 1'b0;
        // ties after reset: core RW 0x340 first, then alternation
        txn(1, 1, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0, 1, 0, 12'h340, 12'h7B0, 0, 32'h1234);
        txn(1, 1, 2'b01, 2'b00, 32'h1, 32'h0, 1, 0, 12'h341, 12'h7B1, 0, 32'h5678);
        txn(1, 1, 2'b10, 2'b11, 32'h2, 32'h4, 1, 1, 12'h342, 12'h7B2, 1, 32'h9ABC);
        txn(1, 1, 2'b11, 2'b10, 32'hF0, 32'h0F, 1, 1, 12'h343, 12'h7B3, 2, 32'hFFFF);
        // debug set and clear-without-write
        txn(0, 1, 2'b00, 2'b10, 32'h0, 32'h8, 0, 1, 12'h0, 12'h7C0, 0, 32'h3);
        txn(0, 1, 2'b00, 2'b11, 32'h0, 32'hF, 0, 0, 12'h0, 12'h7C1, 0, 32'h55);
        // timeout, then answer on the last permitted cycle, then read-only with wen set
        txn(1, 0, 2'b01, 2'b00, 32'hCAFE, 32'h0, 1, 0, 12'h300, 12'h0, 1000, 32'h99);
        txn(1, 0, 2'b01, 2'b00, 32'hBEEF, 32'h0, 1, 0, 12'h301, 12'h0, TIMEOUT - 1, 32'h77);
        txn(1, 0, 2'b00, 2'b00, 32'hFFFF, 32'h0, 1, 0, 12'hF14, 12'h0, 0, 32'hABCD);
        // reset while the write strobe is up
        @(negedge clk);
        core_vld = 1; core_op = 2'b01; core_wen = 1; core_addr = 12'h305; core_wdata = 32'h1111;
        csr_rd_data = 32'h2222;
        @(negedge clk);
        csr_rd_vld = 1;
        @(negedge clk);
        csr_rd_vld = 0;
        chk("pre_rst_wr_en", 32'(csr_wr_en), 1);
        rst = 1;
        @(negedge clk);
        chk("post_rst_wr_en", 32'(csr_wr_en), 0);
        chk("post_rst_rdy", 32'(core_rdy), 0);
        chk("post_rst_rd_req", 32'(csr_rd_req), 0);
        rst = 0; core_vld = 0;
        last_dbg_m = 1'b1; rdata_m = '0;
        @(negedge clk);
        chk("post_rst_idle_rdy", 32'(core_rdy | dbg_rdy), 0);
        txn(1, 1, 2'b10, 2'b01, 32'h10, 32'h20, 1, 1, 12'h306, 12'h7B4, 0, 32'h1);
        // randomized mix
        for (int k = 0; k < 40; k++) begin
            cv = 1'($urandom_range(0, 1));
            dv = cv ? 1'($urandom_range(0, 1)) : 1'b1;
            r = int'($urandom_range(0, 9));
            dly = r < 6 ? r : r == 6 ? TIMEOUT - 1 : r == 7 ? TIMEOUT : r == 8 ? 1000 : TIMEOUT - 2;
            txn(cv, dv, 2'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                12'($urandom), 12'($urandom), dly, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
